uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver that pairs with the team's `TOP_uart_tx` transmitter. It oversamples `RX_IN` at a runtime-selectable prescale and recovers each bit by majority vote. It deserialises LSB-first frames with optional parity and reports the byte with a one-cycle `Data_Valid` strobe, or flags a parity or stop error instead. It sits between the board RX pin (already synchronised) and the command/FIFO logic.

## Interface
- `DATA_SIZE`, default 8: payload width in bits.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low; `RST`=0 clears all state immediately.
- `RX_IN`  in  1  serial line, idle high, already synchronised to `CLK`.
- `Prescale`  in  6  oversampling ratio; 8, 16 and 32 are legal, and any other value is treated as 8.
- `PAR_EN`  in  1  1 means the frame carries a parity bit.
- `PAR_TYP`  in  1  0 selects even parity, 1 selects odd parity.
- `P_DATA`  out  DATA_SIZE  last good payload; holds its value until the next good frame.
- `Data_Valid`  out  1  one-cycle pulse when `P_DATA` is updated.
- `Par_Err`  out  1  one-cycle pulse when the received parity bit mismatches.
- `Stp_Err`  out  1  one-cycle pulse when the stop bit is sampled 0.

## Operation
- Frame format: start bit (0), then `DATA_SIZE` data bits LSB first, then a parity bit if `PAR_EN`=1, then one stop bit (1).
- Parity rule: the parity bit equals XOR of the data bits when `PAR_TYP`=0, and its inverse when `PAR_TYP`=1. Example: 0x9D with odd parity carries parity bit 0.
- `Prescale`, `PAR_EN` and `PAR_TYP` are latched on the IDLE→START transition. Changes during a frame are ignored.
- Edge counter: `edge_cnt` counts 0..P-1 within each bit, where P is the latched prescale. `bit_cnt` counts the bits within the frame.
- Sampling: take `RX_IN` at `edge_cnt` = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, registered.
- Every decision is made at `edge_cnt` = P-1 (end of the bit period).
- State machine:
  - IDLE: when `RX_IN`=0, go to START with `edge_cnt`=1.
  - START: if the sampled bit is 1, treat it as a glitch, go to IDLE and raise no flags. Otherwise go to DATA.
  - DATA: shift the sample into a holding register at bit `bit_cnt`. After `DATA_SIZE` bits, go to PARITY if `PAR_EN`=1, else STOP.
  - PARITY: compare the sample against computed parity and record a pending parity error. Go to STOP.
  - STOP: if the sample is 0, pulse `Stp_Err`. If a parity error is pending, pulse `Par_Err`. Both may pulse in the same cycle. If neither error occurred, load `P_DATA` and pulse `Data_Valid`. Always return to IDLE.
- A frame with any error never updates `P_DATA`.
- Back-to-back frames are supported: IDLE can accept a start bit on the cycle immediately after STOP exits.

## Timing
- Reset values: `P_DATA`=0, `Data_Valid`=0, `Par_Err`=0, `Stp_Err`=0; state=IDLE; all counters 0.
- Reset asserted mid-frame aborts the frame with no strobe. After reset releases, the next low on `RX_IN` starts a new frame.
- Let the first `CLK` edge at which IDLE sees `RX_IN`=0 be edge 0. The result strobes (`Data_Valid`/`Par_Err`/`Stp_Err`) are high on the cycle following edge (1+DATA_SIZE+PAR_EN+1)·P − 1.
  - This is 11·P cycles for 8 bits with parity, 10·P without.
- Each strobe is exactly one cycle wide. There is no handshake; the consumer must capture `P_DATA` on `Data_Valid`.
- A glitch abort in START returns to IDLE at edge P−1 of the start bit.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the legal prescale constants 8/16/32;
  - an `edge_cnt` width constant of 6.
- Sub-module `uart_rx_sampler` holds the edge counter plus the 3-tap majority sampler. It outputs `sampled_bit` and `bit_done` (`edge_cnt`=P-1).
- The top level contains the FSM, bit counter, deserialiser and parity/stop checks.

## Test plan
- Prescale=8, parity enabled and odd, frame 0x9D with parity 0 and stop 1 → `Data_Valid` pulses once 88 cycles after the start edge, `P_DATA`=0x9D, no errors.
- Prescale=16, parity disabled, 0xA5 followed back-to-back by 0x3C → two `Data_Valid` pulses 160 cycles apart, carrying 0xA5 then 0x3C.
- Prescale=8, parity enabled and even, frame 0x9D sent with parity bit 0 (correct value is 1) → `Par_Err` pulses once, `Data_Valid` stays 0, `P_DATA` is unchanged.
- Prescale=32, frame 0x55 with stop bit forced 0 → `Stp_Err` pulses, no `Data_Valid`; the receiver then accepts the next 0x0F correctly.
- Prescale=8, `RX_IN` low for 2 cycles only → glitch abort, no strobes. Also assert `RST` low mid-frame → all outputs go to 0 immediately and the next frame is received cleanly.
- Prescale=8, a single-cycle high glitch at `edge_cnt`=P/2 inside a 0 data bit → the majority vote keeps the bit at 0 and `P_DATA` is correct.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types, constants and helpers for the UART receiver.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam int EDGE_W = 6;

   localparam logic [EDGE_W-1:0] PRESC_8  = 6'd8;
   localparam logic [EDGE_W-1:0] PRESC_16 = 6'd16;
   localparam logic [EDGE_W-1:0] PRESC_32 = 6'd32;

   // Any prescale other than 16 or 32 falls back to 8.
   function automatic logic [EDGE_W-1:0] legal_prescale(input logic [EDGE_W-1:0] p);
      case (p)
         PRESC_16: return PRESC_16;
         PRESC_32: return PRESC_32;
         default:  return PRESC_8;
      endcase
   endfunction

   // 2-of-3 majority vote.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-tap majority sampler around the bit centre.
module uart_rx_sampler
   import uart_rx_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic [EDGE_W-1:0] i_prescale,
   input  logic              i_rx,
   output logic              o_sampled_bit,
   output logic              o_bit_done
);

   localparam logic [EDGE_W-1:0] ONE = 1;

   logic [EDGE_W-1:0] r_edge_cnt;
   logic [1:0]        r_taps;
   logic              r_bit;
   logic [EDGE_W-1:0] w_half;
   logic [EDGE_W-1:0] w_last;

   assign w_half        = i_prescale >> 1;
   assign w_last        = i_prescale - ONE;
   assign o_bit_done    = i_en && (r_edge_cnt == w_last);
   assign o_sampled_bit = r_bit;

   // Edge counter: runs 0..P-1 while a frame is active, parked at 0 otherwise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_edge_cnt <= '0;
      else if (!i_en || (r_edge_cnt == w_last))
         r_edge_cnt <= '0;
      else
         r_edge_cnt <= r_edge_cnt + ONE;
   end

   // Capture the two early taps, then register the vote on the third tap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_taps <= '0;
         r_bit  <= 1'b0;
      end else if (i_en) begin
         if (r_edge_cnt == (w_half - ONE))
            r_taps[0] <= i_rx;
         if (r_edge_cnt == w_half)
            r_taps[1] <= i_rx;
         if (r_edge_cnt == (w_half + ONE))
            r_bit <= maj3(r_taps[0], r_taps[1], i_rx);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: FSM, bit counter, deserialiser and parity/stop checks.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DATA_SIZE = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RX_IN,
   input  logic [5:0]           Prescale,
   input  logic                 PAR_EN,
   input  logic                 PAR_TYP,
   output logic [DATA_SIZE-1:0] P_DATA,
   output logic                 Data_Valid,
   output logic                 Par_Err,
   output logic                 Stp_Err
);

   localparam int              BIT_W    = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);
   localparam logic [BIT_W-1:0] ONE_B    = 1;

   rx_state_e            r_state;
   rx_state_e            w_next;
   logic [EDGE_W-1:0]    r_prescale;
   logic [EDGE_W-1:0]    w_prescale;
   logic                 r_par_en;
   logic                 r_par_typ;
   logic                 r_par_pend;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [DATA_SIZE-1:0] r_shift;
   logic                 w_start;
   logic                 w_en;
   logic                 w_sample;
   logic                 w_bit_done;
   logic                 w_par_exp;

   assign w_start    = (r_state == IDLE) && !RX_IN;
   assign w_en       = (r_state != IDLE) || !RX_IN;
   // In IDLE the live setting is used so the first counted edge already agrees with the latch.
   assign w_prescale = (r_state == IDLE) ? legal_prescale(Prescale) : r_prescale;
   assign w_par_exp  = (^r_shift) ^ r_par_typ;

   uart_rx_sampler u_sampler (
      .i_clk         (CLK),
      .i_rst_n       (RST),
      .i_en          (w_en),
      .i_prescale    (w_prescale),
      .i_rx          (RX_IN),
      .o_sampled_bit (w_sample),
      .o_bit_done    (w_bit_done)
   );

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic; every transition out of a busy state happens at the end of a bit.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:   if (!RX_IN) w_next = START;
         START:  if (w_bit_done) w_next = w_sample ? IDLE : DATA;
         DATA:   if (w_bit_done && (r_bit_cnt == LAST_BIT)) w_next = r_par_en ? PARITY : STOP;
         PARITY: if (w_bit_done) w_next = STOP;
         STOP:   if (w_bit_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Latch the frame configuration when a start edge is seen.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_prescale <= PRESC_8;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
      end else if (w_start) begin
         r_prescale <= legal_prescale(Prescale);
         r_par_en   <= PAR_EN;
         r_par_typ  <= PAR_TYP;
      end
   end

   // Data bit counter and LSB-first shift register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else if (r_state != DATA) begin
         r_bit_cnt <= '0;
      end else if (w_bit_done) begin
         r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + ONE_B;
         r_shift   <= {w_sample, r_shift[DATA_SIZE-1:1]};
      end
   end

   // Parity check held until the stop bit, then one-cycle result strobes.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_par_pend <= 1'b0;
         P_DATA     <= '0;
         Data_Valid <= 1'b0;
         Par_Err    <= 1'b0;
         Stp_Err    <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         Par_Err    <= 1'b0;
         Stp_Err    <= 1'b0;
         if (w_start)
            r_par_pend <= 1'b0;
         if (w_bit_done && (r_state == PARITY))
            r_par_pend <= (w_sample != w_par_exp);
         if (w_bit_done && (r_state == STOP)) begin
            Stp_Err <= !w_sample;
            Par_Err <= r_par_pend;
            if (w_sample && !r_par_pend) begin
               P_DATA     <= r_shift;
               Data_Valid <= 1'b1;
            end
         end
      end
   end

endmodule
